// File: rtl/router_fifo_if.sv
// Router output-channel handshake bundle.
// Ports: write side (write_enb, lfd_state, data_in), read side (read_enb, data_out), flags (full, empty).
interface router_fifo_if #(
   parameter int WIDTH = 8
);
   logic             write_enb;
   logic             read_enb;
   logic             lfd_state;
   logic [WIDTH-1:0] data_in;
   logic [WIDTH-1:0] data_out;
   logic             full;
   logic             empty;

   modport master (
      output write_enb,
      output read_enb,
      output lfd_state,
      output data_in,
      input  data_out,
      input  full,
      input  empty
   );

   modport slave (
      input  write_enb,
      input  read_enb,
      input  lfd_state,
      input  data_in,
      output data_out,
      output full,
      output empty
   );
endinterface

// File: rtl/router_fifo.sv
// Per-destination output buffer of the 1x3 router with packet-length tracking.
// Ports: clk, resetn (sync, active-low), soft_reset (sync clear), bus (router_fifo_if.slave).
module router_fifo #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 8
) (
   input  logic           clk,
   input  logic           resetn,
   input  logic           soft_reset,
   router_fifo_if.slave   bus
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

   logic [WIDTH:0]   mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic [6:0]       pkt_count;
   logic [WIDTH-1:0] data_out_q;
   logic             full_w;
   logic             empty_w;
   logic             wr_acc;
   logic             rd_acc;
   logic             clr;
   logic [WIDTH:0]   rd_entry;
   logic [6:0]       hdr_count;

   assign empty_w = (wr_ptr == rd_ptr);
   assign full_w  = (wr_ptr[AW] != rd_ptr[AW]) &&
                    (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

   assign clr    = !resetn || soft_reset;
   assign wr_acc = bus.write_enb && !full_w && !clr;
   assign rd_acc = bus.read_enb && !empty_w && !clr;

   assign rd_entry = mem[rd_ptr[AW-1:0]];

   // Header byte carries payload length in its upper bits; +1 for parity.
   assign hdr_count = 7'(rd_entry[WIDTH-1:2]) + 7'd1;

   assign bus.full     = full_w;
   assign bus.empty    = empty_w;
   assign bus.data_out = data_out_q;

   // Storage is never cleared; stale entries are unreachable after reset.
   always_ff @(posedge clk) begin
      if (wr_acc)
         mem[wr_ptr[AW-1:0]] <= {bus.lfd_state, bus.data_in};
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         wr_ptr <= '0;
      end else if (wr_acc) begin
         wr_ptr <= wr_ptr + PTR_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         rd_ptr     <= '0;
         pkt_count  <= '0;
         data_out_q <= '0;
      end else if (rd_acc) begin
         rd_ptr     <= rd_ptr + PTR_ONE;
         data_out_q <= rd_entry[WIDTH-1:0];
         if (rd_entry[WIDTH])
            pkt_count <= hdr_count;
         else if (pkt_count != 7'd0)
            pkt_count <= pkt_count - 7'd1;
      end else if (pkt_count == 7'd0) begin
         // Packet fully drained: idle output returns to zero.
         data_out_q <= '0;
      end
   end
endmodule
